// File: rtl/ddr3_emif_arbiter_if.sv
// Bundle between the DDR3 EMIF arbiter, its two pattern requesters and the EMIF Avalon-MM port.
// master: arbiter view (drives grants, read return and EMIF commands); slave: requesters + EMIF view.
// Signals: rd_* read requester, wr_* write requester, ddr_emif_* Avalon-MM command/response.
interface ddr3_emif_arbiter_if;
    // read requester
    logic         rd_req;
    logic [21:0]  rd_addr;
    logic [4:0]   rd_burst;
    logic         rd_gnt;
    logic [255:0] rd_data;
    logic         rd_data_valid;
    // write requester
    logic         wr_req;
    logic [21:0]  wr_addr;
    logic [4:0]   wr_burst;
    logic [255:0] wr_data;
    logic [31:0]  wr_be;
    logic         wr_data_ack;
    logic         wr_done;
    logic [7:0]   rd_outstanding;
    // EMIF Avalon-MM
    logic         ddr_emif_ready;
    logic [255:0] ddr_emif_read_data;
    logic         ddr_emif_rddata_valid;
    logic         ddr_emif_read;
    logic         ddr_emif_write;
    logic [21:0]  ddr_emif_addr;
    logic [255:0] ddr_emif_write_data;
    logic [31:0]  ddr_emif_byte_enable;
    logic [4:0]   ddr_emif_burst_count;

    modport master (
        input  rd_req, rd_addr, rd_burst,
        output rd_gnt, rd_data, rd_data_valid,
        input  wr_req, wr_addr, wr_burst, wr_data, wr_be,
        output wr_data_ack, wr_done, rd_outstanding,
        input  ddr_emif_ready, ddr_emif_read_data, ddr_emif_rddata_valid,
        output ddr_emif_read, ddr_emif_write, ddr_emif_addr, ddr_emif_write_data,
        output ddr_emif_byte_enable, ddr_emif_burst_count
    );

    modport slave (
        output rd_req, rd_addr, rd_burst,
        input  rd_gnt, rd_data, rd_data_valid,
        output wr_req, wr_addr, wr_burst, wr_data, wr_be,
        input  wr_data_ack, wr_done, rd_outstanding,
        output ddr_emif_ready, ddr_emif_read_data, ddr_emif_rddata_valid,
        input  ddr_emif_read, ddr_emif_write, ddr_emif_addr, ddr_emif_write_data,
        input  ddr_emif_byte_enable, ddr_emif_burst_count
    );
endinterface

// File: rtl/ddr3_emif_arbiter.sv
// Purpose: shares one DDR3 EMIF Avalon-MM port between a pattern reader (priority) and a pattern writer.
// Latency: one ARB decision cycle, then the command strobe; read data returned 1 cycle after EMIF valid.
// Backpressure: ddr_emif_ready=0 holds the current command/beat indefinitely; reads also stall at the in-flight cap.
// Ports: ddr_emif_clk, ddr_emif_rst_n (async, active-low), bus (ddr3_emif_arbiter_if.master).
module ddr3_emif_arbiter #(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 64,
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic                   ddr_emif_clk,
    input  logic                   ddr_emif_rst_n,
    ddr3_emif_arbiter_if.master    bus
);
    localparam int         SW    = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [4:0] MAX_B = 5'(MAX_BURST);

    typedef enum logic [1:0] {ARB, RD, WR} state_t;

    state_t         state_q;
    logic           read_q, write_q;
    logic [21:0]    addr_q;
    logic [4:0]     burst_q;
    logic [4:0]     beat_q;
    logic [SW-1:0]  starve_q;
    logic [7:0]     out_q, out_d;
    logic [255:0]   rdata_q;
    logic           rvld_q;

    logic [4:0]     rd_norm, wr_norm;
    logic [8:0]     rd_sum;
    logic           rd_elig, rd_gnt, wr_ack, wr_last;

    function automatic logic [4:0] norm_burst(input logic [4:0] b);
        if (b == 5'd0)
            return 5'd1;
        else if (b > MAX_B)
            return MAX_B;
        else
            return b;
    endfunction

    assign rd_norm = norm_burst(bus.rd_burst);
    assign wr_norm = norm_burst(bus.wr_burst);
    // A read may only start if its whole burst fits under the in-flight cap.
    assign rd_sum  = {1'b0, out_q} + {4'b0, rd_norm};
    assign rd_elig = bus.rd_req && (rd_sum <= 9'(MAX_OUTSTANDING));
    assign rd_gnt  = read_q && bus.ddr_emif_ready;
    assign wr_ack  = write_q && bus.ddr_emif_ready;
    assign wr_last = (beat_q == burst_q - 5'd1);

    // Accepted burst and a returning beat can land in the same cycle; the
    // decrement is skipped at zero so stale beats after reset cannot underflow.
    always_comb begin
        out_d = out_q + (rd_gnt ? {3'b0, burst_q} : 8'd0);
        if (bus.ddr_emif_rddata_valid && (out_d != 8'd0))
            out_d = out_d - 8'd1;
    end

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            state_q  <= ARB;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            burst_q  <= 5'd1;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    // Reads win unless the writer has been passed over LIMIT times in a row.
                    if (rd_elig && !(bus.wr_req && starve_q == SW'(WR_STARVE_LIMIT))) begin
                        state_q <= RD;
                        read_q  <= 1'b1;
                        addr_q  <= bus.rd_addr;
                        burst_q <= rd_norm;
                        if (bus.wr_req)
                            starve_q <= starve_q + SW'(1);
                    end else if (bus.wr_req) begin
                        state_q  <= WR;
                        write_q  <= 1'b1;
                        addr_q   <= bus.wr_addr;
                        burst_q  <= wr_norm;
                        beat_q   <= '0;
                        starve_q <= '0;
                    end
                end
                RD: begin
                    if (bus.ddr_emif_ready) begin
                        read_q  <= 1'b0;
                        state_q <= ARB;
                    end
                end
                WR: begin
                    // wr_req is ignored here: a started burst always runs to completion.
                    if (bus.ddr_emif_ready) begin
                        if (wr_last) begin
                            write_q <= 1'b0;
                            beat_q  <= '0;
                            state_q <= ARB;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            out_q   <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            rdata_q <= bus.ddr_emif_read_data;
            rvld_q  <= bus.ddr_emif_rddata_valid;
        end
    end

    assign bus.rd_gnt               = rd_gnt;
    assign bus.rd_data              = rdata_q;
    assign bus.rd_data_valid        = rvld_q;
    assign bus.wr_data_ack          = wr_ack;
    assign bus.wr_done              = wr_ack && wr_last;
    assign bus.rd_outstanding       = out_q;
    assign bus.ddr_emif_read        = read_q;
    assign bus.ddr_emif_write       = write_q;
    assign bus.ddr_emif_addr        = addr_q;
    assign bus.ddr_emif_burst_count = burst_q;
    assign bus.ddr_emif_write_data  = write_q ? bus.wr_data : '0;
    assign bus.ddr_emif_byte_enable = write_q ? bus.wr_be : '1;
endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Testbench for ddr3_emif_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a command-level reference model.
module tb_ddr3_emif_arbiter;
    localparam int MAXB = 16;
    localparam int MAXO = 64;
    localparam int LIM  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddr3_emif_arbiter_if bus();

    ddr3_emif_arbiter #(
        .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO), .WR_STARVE_LIMIT(LIM)
    ) dut (
        .ddr_emif_clk   (clk),
        .ddr_emif_rst_n (rst_n),
        .bus            (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which command the port is carrying, and what it owes.
    typedef enum {NO_CMD, READ_CMD, WRITE_BURST} cmd_t;
    cmd_t         m_cmd;
    int           m_out, m_starve, m_len, m_beat;
    logic [21:0]  m_addr;
    logic         exp_vld;
    logic [255:0] exp_data;

    // Observation counters and EMIF-side bookkeeping.
    int  owed;
    int  n_gnt, n_done, n_rdv, n_ack, n_rcyc, n_wcyc;
    byte gnt_log[$];
    int  ret_pct = 100;
    int  stale_pct = 0;

    function automatic int norm(input int b);
        if (b < 1) return 1;
        if (b > MAXB) return MAXB;
        return b;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_read();
        m_cmd  = READ_CMD;
        m_addr = bus.rd_addr;
        m_len  = norm(int'(bus.rd_burst));
    endtask

    task automatic start_write();
        m_cmd  = WRITE_BURST;
        m_addr = bus.wr_addr;
        m_len  = norm(int'(bus.wr_burst));
        m_beat = 0;
    endtask

    task automatic model_step();
        bit rd_cmd, wr_cmd, rdy, last, rd_ok;
        int nxt;
        if (!rst_n) begin
            check_eq("rst_read", bus.ddr_emif_read, 0);
            check_eq("rst_write", bus.ddr_emif_write, 0);
            check_eq("rst_outstanding", bus.rd_outstanding, 0);
            check_eq("rst_addr", bus.ddr_emif_addr, 0);
            check_eq("rst_burst_count", bus.ddr_emif_burst_count, 1);
            check_eq("rst_rd_valid", bus.rd_data_valid, 0);
            m_cmd = NO_CMD; m_out = 0; m_starve = 0; m_len = 1; m_beat = 0;
            m_addr = '0; exp_vld = 1'b0; owed = 0;
        end else begin
            rd_cmd = (m_cmd == READ_CMD);
            wr_cmd = (m_cmd == WRITE_BURST);
            rdy    = bus.ddr_emif_ready;
            last   = wr_cmd && (m_beat == m_len - 1);
            check_eq("read_strobe", bus.ddr_emif_read, rd_cmd);
            check_eq("write_strobe", bus.ddr_emif_write, wr_cmd);
            check_eq("rd_gnt", bus.rd_gnt, rd_cmd && rdy);
            check_eq("wr_data_ack", bus.wr_data_ack, wr_cmd && rdy);
            check_eq("wr_done", bus.wr_done, last && rdy);
            check_eq("rd_outstanding", bus.rd_outstanding, m_out);
            check_eq("rd_data_valid", bus.rd_data_valid, exp_vld);
            if (exp_vld) check_eq("rd_data", bus.rd_data, exp_data);
            check_eq("cmd_addr", bus.ddr_emif_addr, m_addr);
            check_eq("burst_count", bus.ddr_emif_burst_count, m_len);
            if (wr_cmd) check_eq("write_data", bus.ddr_emif_write_data, bus.wr_data);
            check_eq("byte_enable", bus.ddr_emif_byte_enable, wr_cmd ? bus.wr_be : 32'hFFFF_FFFF);

            n_gnt  += int'(bus.rd_gnt);
            n_done += int'(bus.wr_done);
            n_rdv  += int'(bus.rd_data_valid);
            n_ack  += int'(bus.wr_data_ack);
            n_rcyc += int'(bus.ddr_emif_read);
            n_wcyc += int'(bus.ddr_emif_write);
            if (bus.rd_gnt) gnt_log.push_back("R");
            if (bus.wr_done) gnt_log.push_back("W");
            if (bus.rd_gnt) owed += int'(bus.ddr_emif_burst_count);
            if (bus.ddr_emif_rddata_valid && owed > 0) owed--;

            nxt = m_out + ((rd_cmd && rdy) ? m_len : 0);
            if (bus.ddr_emif_rddata_valid && nxt > 0) nxt--;
            exp_vld  = bus.ddr_emif_rddata_valid;
            exp_data = bus.ddr_emif_read_data;

            case (m_cmd)
                NO_CMD: begin
                    rd_ok = bus.rd_req && (m_out + norm(int'(bus.rd_burst)) <= MAXO);
                    if (rd_ok && bus.wr_req) begin
                        if (m_starve == LIM) begin start_write(); m_starve = 0; end
                        else begin start_read(); m_starve++; end
                    end else if (rd_ok) begin
                        start_read();
                    end else if (bus.wr_req) begin
                        start_write(); m_starve = 0;
                    end
                end
                READ_CMD:    if (rdy) m_cmd = NO_CMD;
                WRITE_BURST: if (rdy) begin
                    if (m_beat == m_len - 1) m_cmd = NO_CMD;
                    else m_beat++;
                end
                default: m_cmd = NO_CMD;
            endcase
            m_out = nxt;
        end
    endtask

    // One clock: check at the falling edge, then return just after the rising edge
    // with fresh write data and EMIF read returns driven.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        bus.wr_data = rand256();
        bus.wr_be   = $urandom;
        bus.ddr_emif_read_data = rand256();
        if (owed > 0 && $urandom_range(99) < ret_pct)
            bus.ddr_emif_rddata_valid = 1'b1;
        else if (owed == 0 && $urandom_range(99) < stale_pct)
            bus.ddr_emif_rddata_valid = 1'b1;
        else
            bus.ddr_emif_rddata_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.ddr_emif_rddata_valid = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    // which: 0 = read grants, 1 = write completions, 2 = write beat acks
    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int cur;
        for (int k = 0; k < budget; k++) begin
            cur = (which == 0) ? n_gnt : (which == 1) ? n_done : n_ack;
            if (cur >= target) break;
            cycle();
        end
        cur = (which == 0) ? n_gnt : (which == 1) ? n_done : n_ack;
        check_eq(tag, cur >= target, 1);
    endtask

    initial begin
        int bg, br, bv, bw, ba, bd, lb, gs, ds;
        logic [5:0] pat;
        string exp_s;

        rst_n = 1'b0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_burst = 5'd1;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_burst = 5'd1;
        bus.wr_data = '0; bus.wr_be = '0;
        bus.ddr_emif_ready = 1'b1;
        bus.ddr_emif_read_data = '0;
        bus.ddr_emif_rddata_valid = 1'b0;
        do_reset(3);

        // Single read of 4 beats, then its 4 returns.
        bg = n_gnt; br = n_rcyc; bv = n_rdv;
        ret_pct = 0;
        bus.rd_addr = 22'h10; bus.rd_burst = 5'd4; bus.rd_req = 1'b1;
        wait_for(0, bg + 1, 20, "single_gnt_timeout");
        bus.rd_req = 1'b0;
        cycle(); cycle();
        check_eq("single_read_cycles", n_rcyc - br, 1);
        check_eq("single_gnt_pulses", n_gnt - bg, 1);
        check_eq("single_outstanding", bus.rd_outstanding, 4);
        ret_pct = 100;
        repeat (8) cycle();
        check_eq("single_valids", n_rdv - bv, 4);
        check_eq("single_drained", bus.rd_outstanding, 0);

        // Three-beat write with ready low for two cycles on the second beat.
        bw = n_wcyc; ba = n_ack; bd = n_done;
        bus.wr_addr = 22'h123; bus.wr_burst = 5'd3; bus.wr_req = 1'b1;
        pat = 6'b110011;
        for (int k = 0; k < 6; k++) begin
            bus.ddr_emif_ready = pat[k];
            cycle();
        end
        bus.wr_req = 1'b0; bus.ddr_emif_ready = 1'b1;
        cycle(); cycle();
        check_eq("stall_write_cycles", n_wcyc - bw, 5);
        check_eq("stall_acks", n_ack - ba, 3);
        check_eq("stall_done", n_done - bd, 1);

        // Starvation guard: both requesters held, single-beat bursts.
        do_reset(2);
        ret_pct = 100;
        bus.rd_burst = 5'd1; bus.wr_burst = 5'd1;
        bus.rd_addr = 22'h55; bus.wr_addr = 22'h66;
        lb = gnt_log.size();
        bus.rd_req = 1'b1; bus.wr_req = 1'b1;
        for (int k = 0; k < 200 && gnt_log.size() - lb < 10; k++) cycle();
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        check_eq("starve_timeout", gnt_log.size() - lb >= 10, 1);
        exp_s = "RRRRWRRRRW";
        if (gnt_log.size() - lb >= 10)
            for (int k = 0; k < 10; k++) check_eq("starve_order", gnt_log[lb + k], exp_s[k]);
        repeat (6) cycle();

        // Outstanding cap: no returns, 16-beat reads.
        do_reset(2);
        ret_pct = 0;
        bg = n_gnt;
        bus.rd_burst = 5'd16; bus.rd_addr = 22'h200; bus.rd_req = 1'b1;
        wait_for(0, bg + 4, 40, "cap_four_gnts");
        repeat (6) cycle();
        check_eq("cap_gnt_count", n_gnt - bg, 4);
        check_eq("cap_outstanding", bus.rd_outstanding, 64);
        bd = n_done;
        bus.wr_burst = 5'd2; bus.wr_addr = 22'h300; bus.wr_req = 1'b1;
        wait_for(1, bd + 1, 20, "cap_write_served");
        bus.wr_req = 1'b0;
        check_eq("cap_still_blocked", n_gnt - bg, 4);
        ret_pct = 100;
        wait_for(0, bg + 5, 40, "cap_unblocked");
        bus.rd_req = 1'b0;
        repeat (80) cycle();
        check_eq("cap_drained", bus.rd_outstanding, 0);

        // Burst clamping and a grant coinciding with a return.
        do_reset(2);
        ret_pct = 0;
        bus.rd_addr = 22'h2A; bus.rd_burst = 5'd20; bus.rd_req = 1'b1;
        cycle();
        check_eq("clamp_big", bus.ddr_emif_burst_count, 16);
        cycle();
        bus.rd_req = 1'b0;
        check_eq("clamp_big_out", bus.rd_outstanding, 16);
        bus.rd_burst = 5'd0; bus.rd_req = 1'b1;
        cycle();
        check_eq("clamp_zero", bus.ddr_emif_burst_count, 1);
        cycle();
        bus.rd_req = 1'b0;
        check_eq("clamp_zero_out", bus.rd_outstanding, 17);
        bus.rd_burst = 5'd5; bus.rd_req = 1'b1;
        cycle();
        bus.ddr_emif_rddata_valid = 1'b1;
        cycle();
        bus.rd_req = 1'b0;
        check_eq("simul_out", bus.rd_outstanding, 21);
        ret_pct = 100;
        repeat (40) cycle();
        check_eq("simul_drained", bus.rd_outstanding, 0);
        bus.ddr_emif_rddata_valid = 1'b1;
        cycle();
        check_eq("stale_forwarded", bus.rd_data_valid, 1);
        check_eq("stale_saturates", bus.rd_outstanding, 0);

        // Reset in the middle of an 8-beat write.
        do_reset(2);
        ret_pct = 0;
        bg = n_gnt;
        bus.rd_burst = 5'd4; bus.rd_req = 1'b1;
        wait_for(0, bg + 1, 20, "rstw_read_gnt");
        bus.rd_req = 1'b0;
        ba = n_ack;
        bus.wr_burst = 5'd8; bus.wr_addr = 22'h3FF; bus.wr_req = 1'b1;
        wait_for(2, ba + 2, 20, "rstw_two_beats");
        check_eq("rstw_mid_burst", bus.ddr_emif_write, 1);
        rst_n = 1'b0; bus.wr_req = 1'b0;
        #1;
        check_eq("rstw_write_low", bus.ddr_emif_write, 0);
        check_eq("rstw_outstanding", bus.rd_outstanding, 0);
        cycle(); cycle();
        rst_n = 1'b1;
        bg = n_gnt; bv = n_rdv;
        bus.rd_burst = 5'd2; bus.rd_addr = 22'h77; bus.rd_req = 1'b1;
        wait_for(0, bg + 1, 20, "rstw_new_read");
        bus.rd_req = 1'b0;
        ret_pct = 100;
        repeat (10) cycle();
        check_eq("rstw_returns", n_rdv - bv, 2);
        check_eq("rstw_drained", bus.rd_outstanding, 0);

        // Randomized traffic with a reset part-way through.
        do_reset(2);
        ret_pct = 60; stale_pct = 1;
        gs = n_gnt; ds = n_done;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                do_reset(2);
                gs = n_gnt; ds = n_done;
            end
            if (n_gnt != gs) begin gs = n_gnt; bus.rd_req = 1'b0; end
            if (n_done != ds) begin ds = n_done; bus.wr_req = 1'b0; end
            if (!bus.rd_req && $urandom_range(3) == 0) begin
                bus.rd_req = 1'b1;
                bus.rd_addr = 22'($urandom);
                bus.rd_burst = 5'($urandom_range(20));
            end
            if (!bus.wr_req && $urandom_range(5) == 0) begin
                bus.wr_req = 1'b1;
                bus.wr_addr = 22'($urandom);
                bus.wr_burst = 5'($urandom_range(20));
            end
            bus.ddr_emif_ready = ($urandom_range(99) < 80);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
